// File: rtl/cc_timecounter_pkg.sv
// cc_timecounter_pkg
//   Shared constants and types for the FROGGER game-time base.
//   - tc_state_e : control FSM state encoding (IDLE/RUN/PAUSE/EXPIRED)
//   - TC_*       : default widths, ticks per game, comparator terminal value
//   - tc_step    : prescaler step for a given speed level
package cc_timecounter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } tc_state_e;

    localparam int TC_DATAWIDTH   = 24;
    localparam int TC_REMAINWIDTH = 8;
    localparam int TC_GAMETICKS   = 60;

    // Terminal value loaded into the comparator; multiple of 8 so every
    // level step (1/2/4/8) lands on it exactly.
    localparam logic [TC_DATAWIDTH-1:0] TC_TERMINAL = 24'hFFE400;

    // Widest step is 8, which needs 4 bits.
    localparam int TC_STEPWIDTH = 4;

    function automatic logic [TC_STEPWIDTH-1:0] tc_step(input logic [1:0] level);
        return TC_STEPWIDTH'(1) << level;
    endfunction

endpackage

// File: rtl/cc_timecounter_prescaler.sv
// cc_timecounter_prescaler
//   Free-running prescaler counter, wraps modulo 2^DATAWIDTH.
//   Priority: reset > clear > hold > count += step.
//   Ports:
//     i_clk, i_rst_n  clock, synchronous active-low reset
//     i_clear         force count to 0
//     i_hold          freeze count
//     i_step          increment applied when neither clear nor hold
//     o_count         current count
module cc_timecounter_prescaler
    import cc_timecounter_pkg::*;
#(
    parameter int DATAWIDTH = TC_DATAWIDTH,
    parameter int STEPWIDTH = TC_STEPWIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_hold,
    input  logic [STEPWIDTH-1:0] i_step,
    output logic [DATAWIDTH-1:0] o_count
);

    logic [DATAWIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!i_hold) begin
            r_count <= r_count + DATAWIDTH'(i_step);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cc_timecounter.sv
// cc_timecounter
//   FROGGER game-time base. Drives the prescaler count onto the comparator
//   bus, clears it on the comparator's terminal flag (T0, active low), emits
//   one tick per terminal event and counts down the remaining game time.
//   Optional feature macro: CC_TIMECOUNTER_LEVELSPEED_EN
//     defined   : step = 1 << level_InBUS
//     undefined : step = 1, level_InBUS unused
//   Ports:
//     CC_TIMECOUNTER_CLOCK_50          clock
//     CC_TIMECOUNTER_RESET_InLow       synchronous active-low reset
//     CC_TIMECOUNTER_start_InLow       start request (IDLE/EXPIRED only)
//     CC_TIMECOUNTER_pause_InLow       pause level
//     CC_TIMECOUNTER_T0_InLow          comparator terminal flag
//     CC_TIMECOUNTER_level_InBUS       speed level
//     CC_TIMECOUNTER_data_OutBUS       prescaler count
//     CC_TIMECOUNTER_tick_Out          one-cycle tick pulse
//     CC_TIMECOUNTER_remaining_OutBUS  remaining ticks
//     CC_TIMECOUNTER_expired_Out       high in EXPIRED
//     CC_TIMECOUNTER_state_OutBUS      FSM state
module cc_timecounter
    import cc_timecounter_pkg::*;
#(
    parameter int TIMECOUNTER_DATAWIDTH   = TC_DATAWIDTH,
    parameter int TIMECOUNTER_REMAINWIDTH = TC_REMAINWIDTH,
    parameter int TIMECOUNTER_GAMETICKS   = TC_GAMETICKS
) (
    input  logic                               CC_TIMECOUNTER_CLOCK_50,
    input  logic                               CC_TIMECOUNTER_RESET_InLow,
    input  logic                               CC_TIMECOUNTER_start_InLow,
    input  logic                               CC_TIMECOUNTER_pause_InLow,
    input  logic                               CC_TIMECOUNTER_T0_InLow,
    input  logic [1:0]                         CC_TIMECOUNTER_level_InBUS,
    output logic [TIMECOUNTER_DATAWIDTH-1:0]   CC_TIMECOUNTER_data_OutBUS,
    output logic                               CC_TIMECOUNTER_tick_Out,
    output logic [TIMECOUNTER_REMAINWIDTH-1:0] CC_TIMECOUNTER_remaining_OutBUS,
    output logic                               CC_TIMECOUNTER_expired_Out,
    output logic [1:0]                         CC_TIMECOUNTER_state_OutBUS
);

    localparam logic [TIMECOUNTER_REMAINWIDTH-1:0] GAMETICKS_W =
        TIMECOUNTER_REMAINWIDTH'(TIMECOUNTER_GAMETICKS);

    tc_state_e                          r_state, w_state_nxt;
    logic [TIMECOUNTER_REMAINWIDTH-1:0] r_remain, w_remain_nxt;
    logic                               r_tick, w_tick_nxt;
    logic                               w_clear, w_hold;
    logic [TC_STEPWIDTH-1:0]            w_step;

`ifdef CC_TIMECOUNTER_LEVELSPEED_EN
    assign w_step = tc_step(CC_TIMECOUNTER_level_InBUS);
`else
    logic w_level_unused;
    assign w_level_unused = ^CC_TIMECOUNTER_level_InBUS;
    assign w_step         = TC_STEPWIDTH'(1);
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge CC_TIMECOUNTER_CLOCK_50) begin
        if (!CC_TIMECOUNTER_RESET_InLow) begin
            r_state  <= ST_IDLE;
            r_remain <= GAMETICKS_W;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    // ---------------- next state / prescaler control ----------------
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_tick_nxt   = 1'b0;
        w_clear      = 1'b0;
        w_hold       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear      = 1'b1;
                w_remain_nxt = GAMETICKS_W;
                if (!CC_TIMECOUNTER_start_InLow)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!CC_TIMECOUNTER_T0_InLow) begin
                    // Tick wins over a simultaneous pause; the pause then
                    // takes effect with the count already cleared.
                    w_clear      = 1'b1;
                    w_tick_nxt   = 1'b1;
                    w_remain_nxt = (r_remain != '0) ? r_remain - 1'b1 : '0;
                    if (r_remain <= TIMECOUNTER_REMAINWIDTH'(1))
                        w_state_nxt = ST_EXPIRED;
                    else if (!CC_TIMECOUNTER_pause_InLow)
                        w_state_nxt = ST_PAUSE;
                end else if (!CC_TIMECOUNTER_pause_InLow) begin
                    w_hold      = 1'b1;
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                // Count stays frozen on the resume edge too; a count sitting
                // at terminal is handled by T0 in the first RUN cycle.
                w_hold = 1'b1;
                if (CC_TIMECOUNTER_pause_InLow)
                    w_state_nxt = ST_RUN;
            end
            ST_EXPIRED: begin
                w_clear      = 1'b1;
                w_remain_nxt = '0;
                if (!CC_TIMECOUNTER_start_InLow) begin
                    w_remain_nxt = GAMETICKS_W;
                    w_state_nxt  = ST_RUN;
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    cc_timecounter_prescaler #(
        .DATAWIDTH (TIMECOUNTER_DATAWIDTH),
        .STEPWIDTH (TC_STEPWIDTH)
    ) u_prescaler (
        .i_clk   (CC_TIMECOUNTER_CLOCK_50),
        .i_rst_n (CC_TIMECOUNTER_RESET_InLow),
        .i_clear (w_clear),
        .i_hold  (w_hold),
        .i_step  (w_step),
        .o_count (CC_TIMECOUNTER_data_OutBUS)
    );

    assign CC_TIMECOUNTER_tick_Out         = r_tick;
    assign CC_TIMECOUNTER_remaining_OutBUS = r_remain;
    assign CC_TIMECOUNTER_expired_Out      = (r_state == ST_EXPIRED);
    assign CC_TIMECOUNTER_state_OutBUS     = r_state;

endmodule

// File: doc/cc_timecounter.md
# cc_timecounter

Game-time base for FROGGER. Holds the 24-bit free-running prescaler count driven onto the time-comparator data bus, and consumes the comparator's active-low terminal flag T0 to clear the prescaler. Each T0 event produces one game tick and decrements a remaining-time counter. A small control FSM handles start, pause and expiry for the game controller.

## Interface
- TIMECOUNTER_DATAWIDTH, 24, prescaler width; equals the comparator bus width.
- TIMECOUNTER_REMAINWIDTH, 8, remaining-time counter width.
- TIMECOUNTER_GAMETICKS, 60, ticks per game; loaded into remaining at start.

Ports:
- CC_TIMECOUNTER_CLOCK_50  in  1  system clock, all state on rising edge.
- CC_TIMECOUNTER_RESET_InLow  in  1  synchronous, active-low reset.
- CC_TIMECOUNTER_start_InLow  in  1  start request, sampled each cycle.
- CC_TIMECOUNTER_pause_InLow  in  1  level; low = pause requested.
- CC_TIMECOUNTER_T0_InLow  in  1  comparator terminal flag; low = count at terminal.
- CC_TIMECOUNTER_level_InBUS  in  2  speed level; used only with CC_TIMECOUNTER_LEVELSPEED_EN.
- CC_TIMECOUNTER_data_OutBUS  out  24  prescaler count to comparator.
- CC_TIMECOUNTER_tick_Out  out  1  one-cycle pulse per game tick.
- CC_TIMECOUNTER_remaining_OutBUS  out  8  remaining ticks.
- CC_TIMECOUNTER_expired_Out  out  1  high while in EXPIRED.
- CC_TIMECOUNTER_state_OutBUS  out  2  FSM state.

## Operation
- States: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3.
- IDLE: count held 0, remaining = GAMETICKS. start low -> RUN.
- RUN: count += step each cycle. T0 low -> count <= 0, tick <= 1, remaining <= remaining-1. If remaining was 1, same edge -> EXPIRED (tick still pulses). pause low with T0 high -> PAUSE.
- PAUSE: count, remaining frozen; T0 ignored. pause high -> RUN.
- EXPIRED: count held 0, remaining 0, expired=1. start low -> RUN with remaining reloaded to GAMETICKS, count 0.
- start ignored in RUN and PAUSE.
- Simultaneous T0 low and pause low in RUN: tick processed first, then PAUSE. Frozen count at terminal is acted on in the first RUN cycle after resume.
- Arithmetic: count is modulo 2^24. Natural wrap if T0 never arrives; no tick on wrap.
- Default step = 1.
- remaining never decrements below 0.

## Timing
- Reset (RESET_InLow low at edge): state IDLE, data 0, tick 0, remaining GAMETICKS, expired 0. Reset overrides all inputs, including mid-RUN.
- IDLE -> RUN: count first becomes step on the edge after the start edge.
- T0 latency: T0 low sampled at edge N -> count 0 and tick high after edge N, tick low after N+1.
- Tick period in RUN = terminal/step + 1 cycles.
- tick is registered, never asserted outside RUN-exit edges.
- expired rises on the same edge as the final tick.

## Configuration
- CC_TIMECOUNTER_LEVELSPEED_EN defined: step = 1 << level_InBUS (1, 2, 4, 8). The terminal value must be a multiple of 8 so that every step lands on it exactly; the package constant satisfies this.
- CC_TIMECOUNTER_LEVELSPEED_EN undefined: step fixed at 1, level_InBUS unconnected internally.

## Structure
- Package cc_timecounter_pkg holds:
  - state encodings IDLE/RUN/PAUSE/EXPIRED
  - default GAMETICKS
  - comparator terminal constant 24'hFFE400, for bench checks
  - step-width constant
- Sub-module cc_timecounter_prescaler contains the 24-bit counter with clear, hold and step inputs. The FSM and remaining counter live in the top.

## Test plan
- Reset then start low one cycle, T0 high: data reads 1,2,3… from cycle 2; tick stays 0; state RUN.
- Bench drives T0 low when data==10: next cycle data 0, tick 1 for one cycle, remaining 59.
- GAMETICKS=3, T0 pulsed every 5 cycles: three ticks, expired=1 with third tick, remaining 0, data held 0; start reloads remaining to 3.
- pause low at data==7 for 4 cycles: data stays 7, state PAUSE; release -> data 8. pause and T0 low together: tick pulses, then PAUSE with data 0.
- RESET_InLow low mid-RUN at data==1000: next edge data 0, state IDLE, remaining 60, tick 0.
- With CC_TIMECOUNTER_LEVELSPEED_EN, level=2'd3: data 0,8,16…; T0 low at 24'hFFE400 gives tick after 2096257 cycles.
